// File: rtl/rv32_mem_arbiter_if.sv
// Core-side instruction/data request ports and the unified memory bus, bundled for the arbiter.
// Latency: n/a (signal bundle only).
// Backpressure: requests are held valid until *_done; memory stalls the issue phase by withholding mem_gnt.
//
// Modports:
//   master - the arbiter: samples requests and memory responses, drives done/rdata/bus_err and mem_* request.
//   slave  - the environment (core ports plus memory): the mirror image of master.
interface rv32_mem_arbiter_if;
    // instruction port
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    // data port
    logic        d_valid;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        bus_err;
    // unified memory bus
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  i_valid, i_addr, d_valid, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata, bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        output i_valid, i_addr, d_valid, d_we, d_addr, d_wdata, d_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata, bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Round-robin merge of instruction and data requests onto one single-outstanding memory bus.
// Latency: valid -> done is 3 cycles minimum (gnt and rvalid immediate), plus memory stall cycles.
// Backpressure: mem_req held until mem_gnt; requesters hold valid until done; no timeout recovery beyond bus_err.
//
// Ports:
//   clk   - single clock, posedge
//   reset - synchronous, active-high
//   bus   - rv32_mem_arbiter_if.master: i_*/d_* requester ports, bus_err, mem_* memory bus
// Parameter TIMEOUT: WAIT cycles without mem_rvalid before an error response (>= 2).
module rv32_mem_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                reset,
    rv32_mem_arbiter_if.master  bus
);
    localparam int unsigned     CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0]     ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {GNT_INSTR, GNT_DATA} grant_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_cmd_t;

    state_t         state;
    grant_t         last_grant;     // also identifies the owner of the transaction in flight
    logic [CW-1:0]  cnt;
    mem_cmd_t       cmd;
    logic           mem_req_q;
    logic           i_done_q;
    logic           d_done_q;
    logic           bus_err_q;
    logic [31:0]    i_rdata_q;
    logic [31:0]    d_rdata_q;

    logic           pick_data;
    logic           rsp_pulse;
    logic           rsp_fire;
    logic [31:0]    rsp_data;

    // Only one requester: it wins. Both: the one that did not win last time.
    always_comb begin
        pick_data = 1'b0;
        if (bus.d_valid && !bus.i_valid) begin
            pick_data = 1'b1;
        end else if (bus.d_valid && bus.i_valid) begin
            pick_data = (last_grant == GNT_INSTR);
        end
    end

    // While a done pulse is out, the requester has not yet dropped valid;
    // sampling it now would re-grant a request that has just completed.
    assign rsp_pulse = i_done_q | d_done_q;

    // A real response on the final timeout cycle wins over the error response.
    assign rsp_fire = bus.mem_rvalid || (cnt == CNT_LAST);
    assign rsp_data = bus.mem_rvalid ? bus.mem_rdata : ERR_DATA;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GNT_DATA;
            cnt        <= '0;
            cmd        <= '0;
            mem_req_q  <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rsp_pulse && (bus.i_valid || bus.d_valid)) begin
                        if (pick_data) begin
                            last_grant <= GNT_DATA;
                            cmd <= '{we:    bus.d_we,
                                     addr:  bus.d_addr,
                                     wdata: bus.d_wdata,
                                     wstrb: bus.d_we ? bus.d_wstrb : 4'b0000};
                        end else begin
                            last_grant <= GNT_INSTR;
                            cmd <= '{we: 1'b0, addr: bus.i_addr, wdata: 32'h0, wstrb: 4'b0000};
                        end
                        mem_req_q <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        cnt       <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_fire) begin
                        if (last_grant == GNT_DATA) begin
                            d_done_q  <= 1'b1;
                            d_rdata_q <= rsp_data;
                        end else begin
                            i_done_q  <= 1'b1;
                            i_rdata_q <= rsp_data;
                        end
                        bus_err_q <= !bus.mem_rvalid;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cmd.we;
    assign bus.mem_addr  = cmd.addr;
    assign bus.mem_wdata = cmd.wdata;
    assign bus.mem_wstrb = cmd.wstrb;
    assign bus.i_done    = i_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter: vector table, hand sequences and a randomized run
// against a latency/arbitration model. Inputs change 1 time unit after posedge; outputs read there too.
module tb_rv32_mem_arbiter;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic reset;
    rv32_mem_arbiter_if bus ();

    rv32_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } pay_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          gdly;
        int          rdly;       // -1: memory never answers
        logic [31:0] rdata;
        int          exp_lat;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic [3:0]  exp_wstrb;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic pay_t cur_pay();
        return '{bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
    endfunction

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h1000) return 32'h0000_00A0;
        if (a == 32'h2000) return 32'h0000_00B0;
        return ~a;
    endfunction

    task automatic req(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
        if (is_d) begin
            bus.d_valid = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
            bus.d_wstrb = wstrb;
        end else begin
            bus.i_valid = 1'b1;
            bus.i_addr  = addr;
        end
    endtask

    task automatic drop(input bit is_d);
        if (is_d) bus.d_valid = 1'b0;
        else      bus.i_valid = 1'b0;
    endtask

    // One idle cycle after a response: the done pulse must be gone.
    task automatic gap(input string name);
        step();
        check(name, {29'd0, bus.i_done, bus.d_done, bus.bus_err}, 32'd0);
    endtask

    // Plays the memory side until one done pulse appears (bounded). port: 0=instr, 1=data, 2=none.
    task automatic serve(input int gdly, input int rdly, input bit stray, input bit use_fn,
                         input logic [31:0] rdata, output int port, output bit err,
                         output logic [31:0] rd, output int lat, output pay_t pay, output bit proto_ok);
        int phase = 0;
        int gcnt  = 0;
        int rcnt  = 0;
        bit seen  = 0;
        bit fin   = 0;
        port = 2; err = 1'b0; rd = '0; lat = -1; pay = '0; proto_ok = 1'b1;
        for (int c = 1; c <= 60 && !fin; c++) begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0BAD_0BAD;
            if (phase == 0) begin
                bus.mem_rvalid = stray;
                if (bus.mem_req) begin
                    if (!seen) begin
                        pay  = cur_pay();
                        seen = 1'b1;
                    end else if (cur_pay() != pay) begin
                        proto_ok = 1'b0;
                    end
                    if (gcnt == gdly) begin
                        bus.mem_gnt = 1'b1;
                        phase = 1;
                    end else begin
                        gcnt++;
                    end
                end
            end else begin
                if (bus.mem_req) proto_ok = 1'b0;
                if (rcnt == rdly) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = use_fn ? mem_fn(bus.mem_addr) : rdata;
                end
                rcnt++;
            end
            step();
            if (bus.i_done && bus.d_done) proto_ok = 1'b0;
            if (bus.bus_err && !(bus.i_done || bus.d_done)) proto_ok = 1'b0;
            if (bus.i_done || bus.d_done) begin
                port = int'(bus.d_done);
                err  = bus.bus_err;
                rd   = bus.d_done ? bus.d_rdata : bus.i_rdata;
                lat  = c;
                fin  = 1'b1;
            end
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[9];
        int          port, lat;
        bit          err, ok;
        logic [31:0] rd;
        pay_t        pay;
        bit          nodone;

        vt[0] = '{1, 0, 32'h100, 32'h0,         4'hF, 0,  0, 32'h1234_5678, 3,  0, 1, 32'h1234_5678, 4'h0};
        vt[1] = '{0, 0, 32'h200, 32'h0,         4'h0, 0,  0, 32'hA5A5_0001, 3,  0, 1, 32'hA5A5_0001, 4'h0};
        vt[2] = '{1, 1, 32'h104, 32'hCAFE_F00D, 4'h3, 5,  0, 32'h0,         8,  0, 0, 32'h0,         4'h3};
        vt[3] = '{0, 0, 32'h204, 32'h0,         4'h0, 2,  3, 32'h5555_AAAA, 8,  0, 1, 32'h5555_AAAA, 4'h0};
        vt[4] = '{1, 0, 32'h108, 32'h0,         4'hF, 0, -1, 32'h0,         10, 1, 1, 32'hDEAD_BEEF, 4'h0};
        vt[5] = '{1, 0, 32'h10C, 32'h0,         4'hF, 0,  7, 32'h7777_0007, 10, 0, 1, 32'h7777_0007, 4'h0};
        vt[6] = '{0, 0, 32'h208, 32'h0,         4'h0, 3, -1, 32'h0,         13, 1, 1, 32'hDEAD_BEEF, 4'h0};
        vt[7] = '{1, 1, 32'h110, 32'h0102_0304, 4'hC, 1,  6, 32'h0,         10, 0, 0, 32'h0,         4'hC};
        vt[8] = '{1, 1, 32'h114, 32'h1111_2222, 4'hF, 0, -1, 32'h0,         10, 1, 1, 32'hDEAD_BEEF, 4'hF};

        reset = 1'b1;
        bus.i_valid = 0; bus.i_addr = 0;
        bus.d_valid = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        step();
        step();

        // Reset state
        check("rst_done",  {29'd0, bus.i_done, bus.d_done, bus.bus_err}, 32'd0);
        check("rst_req",   {31'd0, bus.mem_req}, 32'd0);
        check("rst_we",    {31'd0, bus.mem_we}, 32'd0);
        check("rst_addr",  bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        check("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
        reset = 1'b0;
        step();

        // Tie from reset: instruction wins first, then alternation.
        req(0, 0, 32'h1000, 32'h0, 4'h0);
        req(1, 0, 32'h2000, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            serve(0, 0, 0, 1, 32'h0, port, err, rd, lat, pay, ok);
            check($sformatf("tie%0d_port", k), port, k % 2);
            check($sformatf("tie%0d_rdata", k), rd, (k % 2) ? 32'hB0 : 32'hA0);
            check($sformatf("tie%0d_err", k), 32'(err), 32'd0);
        end
        drop(0);
        drop(1);
        gap("tie_gap");

        // Vector table
        for (int i = 0; i < 9; i++) begin
            req(vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wstrb);
            serve(vt[i].gdly, vt[i].rdly, 0, 0, vt[i].rdata, port, err, rd, lat, pay, ok);
            drop(vt[i].is_d);
            check($sformatf("tbl%0d_port", i), port, int'(vt[i].is_d));
            check($sformatf("tbl%0d_lat", i), lat, vt[i].exp_lat);
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(vt[i].exp_err));
            if (vt[i].chk_rd) check($sformatf("tbl%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("tbl%0d_mem_we", i), 32'(pay.we), 32'(vt[i].we));
            check($sformatf("tbl%0d_mem_addr", i), pay.addr, vt[i].addr);
            check($sformatf("tbl%0d_mem_wstrb", i), 32'(pay.wstrb), 32'(vt[i].exp_wstrb));
            if (vt[i].we) check($sformatf("tbl%0d_mem_wdata", i), pay.wdata, vt[i].wdata);
            check($sformatf("tbl%0d_protocol", i), 32'(ok), 32'd1);
            gap($sformatf("tbl%0d_pulse", i));
        end

        // Reset while in WAIT, then a late rvalid.
        req(1, 0, 32'h300, 32'h0, 4'h0);
        step();
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drop(1);
        check("rstw_done", {29'd0, bus.i_done, bus.d_done, bus.bus_err}, 32'd0);
        check("rstw_req", {31'd0, bus.mem_req}, 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BAD_0001;
        step();
        bus.mem_rvalid = 1'b0;
        check("rstw_late_rvalid", {29'd0, bus.i_done, bus.d_done, bus.bus_err}, 32'd0);
        step();
        check("rstw_idle", {29'd0, bus.i_done, bus.d_done, bus.mem_req}, 32'd0);
        req(0, 0, 32'h304, 32'h0, 4'h0);
        serve(0, 0, 0, 0, 32'h3040_3040, port, err, rd, lat, pay, ok);
        drop(0);
        check("rstw_next_port", port, 0);
        check("rstw_next_lat", lat, 3);
        check("rstw_next_rdata", rd, 32'h3040_3040);
        gap("rstw_next_pulse");

        // Stray rvalid in IDLE (and through ISSUE), then an instruction fetch.
        nodone = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BAD_0002;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.i_done || bus.d_done || bus.bus_err || bus.mem_req) nodone = 1'b0;
        end
        check("stray_idle", 32'(nodone), 32'd1);
        req(0, 0, 32'h400, 32'h0, 4'h0);
        serve(2, 1, 1, 0, 32'h4000_0004, port, err, rd, lat, pay, ok);
        drop(0);
        check("stray_port", port, 0);
        check("stray_lat", lat, 6);
        check("stray_rdata", rd, 32'h4000_0004);
        check("stray_err", 32'(err), 32'd0);
        gap("stray_pulse");

        // Randomized traffic against the model: round robin on ties,
        // latency 3+g+r (or 2+g+TIMEOUT on timeout), +1 when queued behind a just-finished response.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        begin
            bit          last_d = 1'b1;
            int          mask, nserve;
            bit          win;
            logic [31:0] ia, da, dw, data;
            logic [3:0]  ds;
            bit          dwe;
            for (int n = 0; n < 40; n++) begin
                mask = $urandom_range(1, 3);
                ia   = {$urandom, 2'b00} & 32'h0000_FFFC;
                da   = $urandom & 32'h0000_FFFF;
                dw   = $urandom;
                ds   = 4'($urandom);
                dwe  = 1'($urandom);
                if (mask[0]) req(0, 0, ia, 32'h0, 4'h0);
                if (mask[1]) req(1, dwe, da, dw, ds);
                win    = (mask == 3) ? !last_d : (mask == 2);
                nserve = (mask == 3) ? 2 : 1;
                for (int s = 0; s < nserve; s++) begin
                    int g, r, elat;
                    bit eerr;
                    g    = $urandom_range(0, 3);
                    r    = $urandom_range(0, 9);
                    data = $urandom;
                    eerr = (r > int'(TO) - 1);
                    elat = (eerr ? 2 + g + int'(TO) : 3 + g + r) + s;
                    serve(g, r, 0, 0, data, port, err, rd, lat, pay, ok);
                    check($sformatf("rnd%0d.%0d_port", n, s), port, int'(win));
                    check($sformatf("rnd%0d.%0d_lat", n, s), lat, elat);
                    check($sformatf("rnd%0d.%0d_err", n, s), 32'(err), 32'(eerr));
                    if (eerr) check($sformatf("rnd%0d.%0d_rdata", n, s), rd, 32'hDEAD_BEEF);
                    else if (!(win && dwe)) check($sformatf("rnd%0d.%0d_rdata", n, s), rd, data);
                    check($sformatf("rnd%0d.%0d_addr", n, s), pay.addr, win ? da : ia);
                    check($sformatf("rnd%0d.%0d_protocol", n, s), 32'(ok), 32'd1);
                    last_d = win;
                    drop(win);
                    win = !win;
                end
                gap($sformatf("rnd%0d_pulse", n));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
